// File: rtl/conv5x5_pkg.sv
// Shared types and constants for the 5x5 convolution engine.
package conv5x5_pkg;

    localparam int unsigned KSIZE    = 5;
    localparam int unsigned NUM_TAPS = KSIZE * KSIZE;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Per-window tag travelling alongside the datapath.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // Result width that holds 25 full-precision signed products.
    function automatic int unsigned out_width(input int unsigned bit_width);
        return 2 * bit_width + KSIZE;
    endfunction

endpackage

// File: rtl/conv5x5_engine_row_mac.sv
// One kernel row: five registered signed products, then a registered 5-term sum.
module conv_row_mac
    import conv5x5_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned SUM_WIDTH = 2 * BIT_WIDTH + 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIT_WIDTH*KSIZE-1:0]  pix,
    input  logic [BIT_WIDTH*KSIZE-1:0]  wts,
    output logic signed [SUM_WIDTH-1:0] row_sum
);

    localparam int unsigned PROD_WIDTH = 2 * BIT_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod_q [KSIZE];
    logic signed [PROD_WIDTH-1:0] prod_d [KSIZE];
    logic signed [SUM_WIDTH-1:0]  sum_q;
    logic signed [SUM_WIDTH-1:0]  sum_d;

    always_comb begin
        for (int j = 0; j < KSIZE; j++) begin
            prod_d[j] = PROD_WIDTH'($signed(pix[BIT_WIDTH*j +: BIT_WIDTH]) *
                                    $signed(wts[BIT_WIDTH*j +: BIT_WIDTH]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < KSIZE; j++) begin
            sum_d = sum_d + SUM_WIDTH'(prod_q[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < KSIZE; j++) begin
                prod_q[j] <= '0;
            end
            sum_q <= '0;
        end else begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
        end
    end

    assign row_sum = sum_q;

endmodule

// File: rtl/conv5x5_engine.sv
// 5x5 signed convolution behind a sliding-window buffer: weight loader FSM,
// stream position tracking, window tagging and a 3-stage multiply/add pipeline.
module conv5x5_engine
    import conv5x5_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned SIZE      = 32,
    parameter int unsigned OUT_WIDTH = out_width(BIT_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        frame_start,
    input  logic [BIT_WIDTH*KSIZE-1:0]  win0,
    input  logic [BIT_WIDTH*KSIZE-1:0]  win1,
    input  logic [BIT_WIDTH*KSIZE-1:0]  win2,
    input  logic [BIT_WIDTH*KSIZE-1:0]  win3,
    input  logic [BIT_WIDTH*KSIZE-1:0]  win4,
    input  logic                        w_start,
    input  logic                        w_valid,
    input  logic [BIT_WIDTH-1:0]        w_data,
    output logic                        w_ready,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid,
    output logic                        frame_done
);

    localparam int unsigned ROW_W = BIT_WIDTH * KSIZE;
    localparam int unsigned SUM_W = 2 * BIT_WIDTH + 3;
    localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_TAPS);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ROW_W-1:0]            w_q [KSIZE];
    logic [ROW_W-1:0]            w_d [KSIZE];
    logic [CNT_W-1:0]            col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0]            cur_col, cur_row;
    tag_t                        tag_q, tag_d, tag0_q, tag0_d, tag1_q, tag1_d;
    logic signed [OUT_WIDTH-1:0] out_q, out_d, total;
    logic                        out_valid_q, out_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic                        w_ready_q, w_ready_d;

    logic [ROW_W-1:0]            win_rows [KSIZE];
    logic signed [SUM_W-1:0]     row_sum [KSIZE];

    assign win_rows[0] = win0;
    assign win_rows[1] = win1;
    assign win_rows[2] = win2;
    assign win_rows[3] = win3;
    assign win_rows[4] = win4;

    for (genvar i = 0; i < KSIZE; i++) begin : g_row
        conv_row_mac #(
            .BIT_WIDTH (BIT_WIDTH),
            .SUM_WIDTH (SUM_W)
        ) u_mac (
            .clk     (clk),
            .rst     (rst),
            .pix     (win_rows[i]),
            .wts     (w_q[i]),
            .row_sum (row_sum[i])
        );
    end

    // Weight loader: w_start always restarts, w_valid only counts while loading.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        w_d     = w_q;
        if (w_start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
        end else if (state_q == ST_LOAD && w_valid) begin
            for (int k = 0; k < int'(NUM_TAPS); k++) begin
                if (idx_q == IDX_W'(k)) begin
                    w_d[k / KSIZE][BIT_WIDTH*(k % KSIZE) +: BIT_WIDTH] = w_data;
                end
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_TAPS - 1)) begin
                state_d = ST_RUN;
            end
        end
        w_ready_d = (state_d == ST_RUN);
    end

    // Stream position of the pixel pushed this cycle; frame_start makes it (0,0).
    always_comb begin
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        col_d   = cur_col;
        row_d   = cur_row;
        if (en) begin
            if (cur_col == CNT_W'(SIZE - 1)) begin
                col_d = '0;
                row_d = (cur_row == CNT_W'(SIZE - 1)) ? '0 : cur_row + CNT_W'(1);
            end else begin
                col_d = cur_col + CNT_W'(1);
            end
        end
    end

    // Launch tag; a coincident w_start means RUN is being left, so no tag.
    always_comb begin
        tag_d.valid = en && !w_start && (state_q == ST_RUN) &&
                      (cur_row >= CNT_W'(KSIZE - 1)) && (cur_col >= CNT_W'(KSIZE - 1));
        tag_d.last  = tag_d.valid && (cur_row == CNT_W'(SIZE - 1)) &&
                      (cur_col == CNT_W'(SIZE - 1));
        tag0_d      = tag_q;
        tag1_d      = tag0_q;
    end

    always_comb begin
        total = '0;
        for (int i = 0; i < KSIZE; i++) begin
            total = total + OUT_WIDTH'(row_sum[i]);
        end
        out_d        = tag1_q.valid ? total : out_q;
        out_valid_d  = tag1_q.valid;
        frame_done_d = tag1_q.last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            idx_q        <= '0;
            for (int i = 0; i < KSIZE; i++) begin
                w_q[i] <= '0;
            end
            col_q        <= '0;
            row_q        <= '0;
            tag_q        <= '0;
            tag0_q       <= '0;
            tag1_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            w_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            w_q          <= w_d;
            col_q        <= col_d;
            row_q        <= row_d;
            tag_q        <= tag_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            w_ready_q    <= w_ready_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign w_ready    = w_ready_q;

endmodule

// File: tb/tb_conv5x5_engine.sv
// Scoreboard bench for conv5x5_engine at SIZE=8: directed frames with
// hand-derived expected results queued at push time and checked by a monitor.
module tb_conv5x5_engine;

    localparam int unsigned BW   = 8;
    localparam int unsigned SZ   = 8;
    localparam int unsigned OW   = 2 * BW + 5;

    typedef struct {
        int val;
        bit last;
        int cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst, en, frame_start, w_start, w_valid;
    logic [BW-1:0]        w_data;
    logic [BW*5-1:0]      win0, win1, win2, win3, win4;
    logic                 w_ready, out_valid, frame_done;
    logic signed [OW-1:0] dut_out;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pix_mode = 0;   // 0: all ones, 1: raster index mod 128, 2: -128
    int   exp_mode = 0;   // 0: 25, 1: newest pixel, 2: 409600, 3: 25*v-450
    int   m_row = 0, m_col = 0, m_idx = 0;
    bit   m_run = 0, m_load = 0;
    int   last_r = -10, last_c = -10;

    conv5x5_engine #(.BIT_WIDTH(BW), .SIZE(SZ), .OUT_WIDTH(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .frame_start (frame_start),
        .win0        (win0),
        .win1        (win1),
        .win2        (win2),
        .win3        (win3),
        .win4        (win4),
        .w_start     (w_start),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .out         (dut_out),
        .out_valid   (out_valid),
        .frame_done  (frame_done)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int pix(input int r, input int c);
        if (r < 0 || c < 0) return 0;
        case (pix_mode)
            0:       return 1;
            1:       return (r * 8 + c) % 128;
            default: return -128;
        endcase
    endfunction

    function automatic int exp_val(input int r, input int c);
        int v;
        v = r * 8 + c;
        case (exp_mode)
            0:       return 25;
            1:       return v;
            2:       return 409600;
            default: return 25 * v - 450;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Mimics the window buffer: the window of the last pushed pixel is presented.
    task automatic set_window(input int r, input int c);
        logic [BW*5-1:0] rows [5];
        for (int i = 0; i < 5; i++) begin
            rows[i] = '0;
            for (int j = 0; j < 5; j++) rows[i][BW*j +: BW] = BW'(pix(r - i, c - j));
        end
        win0 = rows[0]; win1 = rows[1]; win2 = rows[2]; win3 = rows[3]; win4 = rows[4];
    endtask

    task automatic cycle(input bit e, input bit fs, input bit ws, input bit wv,
                         input logic [BW-1:0] wd);
        int r, c;
        exp_t x;
        @(negedge clk);
        set_window(last_r, last_c);
        en = e; frame_start = fs; w_start = ws; w_valid = wv; w_data = wd;
        if (e) begin
            r = fs ? 0 : m_row;
            c = fs ? 0 : m_col;
            if (m_run && !ws && r >= 4 && c >= 4) begin
                x.val  = exp_val(r, c);
                x.last = (r == 7 && c == 7);
                x.cyc  = cyc + 4;
                sb.push_back(x);
            end
            last_r = r; last_c = c;
            if (c == 7) begin
                m_col = 0;
                m_row = (r == 7) ? 0 : r + 1;
            end else begin
                m_col = c + 1;
                m_row = r;
            end
        end else if (fs) begin
            m_row = 0; m_col = 0;
        end
        if (ws) begin
            m_load = 1; m_run = 0; m_idx = 0;
        end else if (wv && m_load) begin
            m_idx++;
            if (m_idx == 25) begin
                m_load = 0; m_run = 1;
            end
        end
    endtask

    // kind 0: all ones, 1: only w[0][0]=1, 2: all -128
    task automatic load_weights(input int kind, input bit with_en);
        int wd;
        cycle(with_en, 0, 1, 0, '0);
        for (int k = 0; k < 25; k++) begin
            wd = (kind == 0) ? 1 : (kind == 1) ? ((k == 0) ? 1 : 0) : -128;
            cycle(with_en, 0, 0, 1, BW'(wd));
        end
    endtask

    task automatic run_pixels(input int n, input bit fs_first, input int gap);
        for (int p = 0; p < n; p++) begin
            cycle(1, fs_first && p == 0, 0, 0, '0);
            for (int g = 0; g < gap; g++) cycle(0, 0, 0, 0, '0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; frame_start = 0; w_start = 0; w_valid = 0;
        sb.delete();
        m_run = 0; m_load = 0; m_row = 0; m_col = 0; m_idx = 0;
        @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(dut_out), 0);
        check("rst_w_ready", int'(w_ready), 0);
        check("rst_frame_done", int'(frame_done), 0);
        @(negedge clk);
        rst = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: out_valid=1 out=%0d at cycle %0d, none expected",
                             int'(dut_out), cyc);
                end else begin
                    x = sb.pop_front();
                    if (int'(dut_out) != x.val || frame_done !== x.last || cyc != x.cyc) begin
                        n_err++;
                        $display("FAIL result: got out=%0d done=%0b cyc=%0d expected out=%0d done=%0b cyc=%0d",
                                 int'(dut_out), frame_done, cyc, x.val, x.last, x.cyc);
                    end
                end
            end else if (frame_done === 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL stray_frame_done: got frame_done=1 expected 0 at cycle %0d", cyc);
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                x = sb.pop_front();
                n_vec++; n_err++;
                $display("FAIL missing_out: got out_valid=0 expected out=%0d at cycle %0d",
                         x.val, x.cyc);
            end
        end
    end

    initial begin
        rst = 1; en = 0; frame_start = 0; w_start = 0; w_valid = 0; w_data = '0;
        set_window(-10, -10);
        repeat (3) @(negedge clk);
        check("reset_out", int'(dut_out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_w_ready", int'(w_ready), 0);
        check("reset_frame_done", int'(frame_done), 0);
        rst = 0;

        // All-ones weights over all-ones pixels.
        load_weights(0, 0);
        cycle(0, 0, 0, 0, '0);
        check("w_ready_after_load", int'(w_ready), 1);
        pix_mode = 0; exp_mode = 0;
        run_pixels(64, 1, 0);

        // Single-tap kernel picks the newest pixel.
        load_weights(1, 0);
        pix_mode = 1; exp_mode = 1;
        run_pixels(64, 1, 0);

        // Same, with en every other cycle.
        run_pixels(64, 1, 1);

        // Extreme negative operands.
        load_weights(2, 0);
        pix_mode = 2; exp_mode = 2;
        run_pixels(64, 1, 0);

        // Reload mid-frame with en still streaming.
        load_weights(1, 0);
        pix_mode = 1; exp_mode = 1;
        run_pixels(38, 1, 0);
        exp_mode = 3;
        load_weights(0, 1);
        check("w_ready_during_stream", int'(w_ready), 0);
        cycle(1, 1, 0, 0, '0);
        check("w_ready_after_reload", int'(w_ready), 1);
        run_pixels(63, 0, 0);

        // Reset with results in flight, then no outputs until a reload.
        run_pixels(40, 1, 0);
        do_reset();
        run_pixels(64, 1, 0);
        check("w_ready_no_reload", int'(w_ready), 0);
        load_weights(0, 0);
        run_pixels(64, 1, 0);

        repeat (10) cycle(0, 0, 0, 0, '0);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv5x5_engine.md
Name: conv5x5_engine

Overview:
- Consumes the five packed window rows produced by the 5x5 sliding-window buffer and computes one signed 5x5 convolution per valid window position.
- Tracks the pixel stream position internally so it can flag which windows are fully inside the frame; windows that straddle row or frame edges are discarded.
- Holds a serially loaded 25-entry weight set and runs a 3-stage multiply/add pipeline.
- Sits directly downstream of the window buffer, driven by the same clk/en.

Parameters:
- BIT_WIDTH, 8, signed width of pixels and weights.
- SIZE, 32, frame width and height in pixels (square frame, SIZE >= 5).
- OUT_WIDTH, 2*BIT_WIDTH+5, signed result width; holds 25 full-precision products without overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pixel-push strobe, the same signal that advances the window buffer.
- frame_start  in  1  resynchronises the position counters; if coincident with en, that pixel is (0,0).
- win0..win4  in  BIT_WIDTH*5 each  window rows; win0 is the newest row; field x [BIT_WIDTH*(x+1)-1 : BIT_WIDTH*x], x=0 is the newest column.
- w_start  in  1  begins a weight load.
- w_valid  in  1  w_data is valid this cycle.
- w_data  in  BIT_WIDTH  signed weight.
- w_ready  out  1  weights loaded, engine in RUN.
- out  out  OUT_WIDTH  signed convolution result.
- out_valid  out  1  one-cycle strobe, out is valid.
- frame_done  out  1  pulses together with the last valid output of a frame.

Behaviour:
- Reset values: state EMPTY; all weights 0; col/row counters 0; pipeline valid bits 0; out=0, out_valid=0, w_ready=0, frame_done=0.
- Weights:
  - Index k = 5*i + j multiplies winI field j (i = row, j = column).
  - result = sum over i,j of w[i][j]*winI[j], with full signed precision.
- FSM states: EMPTY, LOAD, RUN.
  - w_start in any state -> LOAD and index := 0. w_start wins over a coincident w_valid; that w_data is dropped.
  - In LOAD, each w_valid writes w[index] and increments index. The write with index=24 moves the FSM to RUN.
  - w_valid outside LOAD is ignored.
  - w_ready = (state == RUN).
  - Weights are written in place; outputs produced during a reload are suppressed, so stale/new mixing is never visible.
- Position counters:
  - Advance only on en: col increments, and wraps to 0 after SIZE-1 while row increments.
  - row wraps to 0 after SIZE-1.
  - frame_start clears both counters. With en in the same cycle, the pixel takes position (0,0) and the counters move to col=1.
- Window tagging:
  - When en is sampled at edge E0 for pixel (r,c), the window with that pixel at win0 field 0 is visible after E0.
  - Tag t = (r >= 4) && (c >= 4) && (state == RUN), evaluated at E0.
- Pipeline (free-running, never stalls):
  - E0+1: 25 products registered, carrying valid0 = t and last0 = t && r==SIZE-1 && c==SIZE-1.
  - E0+2: 5 row sums registered.
  - E0+3: final sum registered into out; out_valid and frame_done updated.
  - Latency: out_valid is high in the cycle after E0+3 and for one cycle only.
  - Back-to-back en gives one result per cycle. en gaps produce out_valid=0 bubbles.
  - out holds its last value when out_valid=0.
- Output count: each frame yields exactly (SIZE-4)^2 valid outputs, in raster order.
- Edge cases:
  - Leaving RUN (via w_start) kills tags at their launch edge; results already in flight still complete.
  - rst mid-frame clears everything, including in-flight valid bits, on the same edge.

Decomposition:
- Shared header: OUT_WIDTH derivation, KSIZE=5 localparam, FSM state encodings.
- One sub-module, conv_row_mac:
  - Five signed multiplies into registers, then a registered 5-term sum.
  - Instantiated five times.
- The top level holds the FSM, weight file, counters, tag pipeline and final adder.

Test Plan:
- SIZE=8. Load 25 weights of 1, then stream 64 pixels of value 1 with en continuous -> 16 outputs, all 25. The first out_valid appears 3 edges after the 37th en; the last carries frame_done.
- Weights all 0 except w[0][0]=1, pixels = raster index mod 128 -> each out equals the newest pixel value (36, 37, 38, 39, 44, ...).
- Weights -128, pixels -128, SIZE=8 -> out = 25*16384 = 409600, with no overflow at OUT_WIDTH=21.
- Stream with en high every other cycle -> out_valid alternates, with the same values as the continuous case.
- w_start during a frame, 25 loads, with en continuing -> no out_valid for pixels pushed while in LOAD. Outputs resume with the new weights once w_ready=1.
- rst asserted mid-frame with results in flight -> out_valid=0 and out=0 on the next edge. w_ready=0, and no outputs until a reload completes.
